mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
- Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter MEM_WORDS, default 64: data-memory depth in 32-bit words.
REQ-002 The block SHALL have parameter BASE_ADDR, default 1024: byte address mapped to word 0.
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 2: stall cycles per memory access; legal range 1..15.
- Ports (name, direction, width, meaning):
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-low.
REQ-006 wb_en_in, mem_r_en_in, mem_w_en_in  in  1 each  control bits from the EXE/MEM register.
REQ-007 alu_res_in  in  32  effective byte address, or result passed through.
REQ-008 val_rm_in  in  32  store data.
REQ-009 dst_in  in  4  destination register.
REQ-010 ready  out  1  combinational; upstream freezes the IF/ID/EXE registers while it is 0.
REQ-011 wb_en_out, mem_r_en_out  out  1 each  registered MEM/WB control bits.
REQ-012 alu_res_out, mem_data_out  out  32 each  registered MEM/WB data.
REQ-013 dst_out  out  4  registered MEM/WB destination.

Function
REQ-014 Word index SHALL be (alu_res_in - BASE_ADDR)[31:2] modulo MEM_WORDS; byte offset bits [1:0] ignored; out-of-range addresses wrap, no error.
REQ-015 FSM states SHALL be IDLE, WAIT, DONE.
- IDLE: request (mem_r_en_in|mem_w_en_in) -> WAIT, counter loaded WAIT_CYCLES-1; else stay.
- WAIT: counter decrements; counter==0 -> DONE.
- DONE: -> IDLE unconditionally.
REQ-016 ready SHALL be 1 in IDLE with no request, 0 in IDLE with a request, 0 in WAIT, 1 in DONE; each access spans exactly WAIT_CYCLES+1 cycles.
REQ-017 A non-memory op SHALL pass to the MEM/WB outputs with 1-cycle latency and no stall.
REQ-018 Upstream holds all inputs stable while ready=0; the block SHALL NOT latch request inputs.
REQ-019 A store SHALL commit to memory only at the clock edge ending the DONE cycle.
REQ-020 A load SHALL present the addressed word (combinational array read) to mem_data_out at the DONE-ending edge.
REQ-021 The MEM/WB register SHALL load all outputs on each edge where ready=1.
REQ-022 On each edge where ready=0, the MEM/WB register SHALL load a bubble (wb_en_out=0, mem_r_en_out=0) and hold its data fields.
REQ-023 With mem_r_en_in and mem_w_en_in both 1, write SHALL win: store committed, mem_r_en_out=0, mem_data_out held.
REQ-024 Back-to-back accesses SHALL restart from IDLE: DONE -> IDLE -> WAIT, so ready=0 again in the cycle after DONE.
REQ-025 A store followed immediately by a load to the same word SHALL return the new data.

Reset
REQ-026 On rst=0: state IDLE, counter 0, all registered outputs 0.
REQ-027 With reset asserted, ready SHALL be 1.
REQ-028 Reset mid-access (WAIT or DONE before the edge) SHALL abort; no store committed.
REQ-029 Memory contents SHALL NOT be reset.

Structure
REQ-030 A shared package mem_pkg SHALL hold the FSM state enum and the BASE_ADDR/MEM_WORDS default constants.
REQ-031 A single sub-module data_memory SHALL hold the array: synchronous write with write-enable, asynchronous read, parameterized depth.

Verification
REQ-032 The bench SHALL check: reset, then non-memory op wb_en_in=1, alu_res_in=0x5, dst_in=3 -> ready stays 1; next cycle wb_en_out=1, alu_res_out=0x5, dst_out=3.
REQ-033 The bench SHALL check: store val_rm_in=0xDEADBEEF at 0x408 -> ready=0 for 2 cycles, 1 in the 3rd; wb_en_out=0 during the stall; word 2 = 0xDEADBEEF afterwards.
REQ-034 The bench SHALL check: load from 0x408 right after that store, wb_en_in=1, dst_in=7 -> 3-cycle access; then mem_data_out=0xDEADBEEF, mem_r_en_out=1, wb_en_out=1, dst_out=7.
REQ-035 The bench SHALL check: store 0x1234 at 0x500 (MEM_WORDS=64) -> lands in word 0 (wrap); load from 0x400 returns 0x1234.
REQ-036 The bench SHALL check: rst pulsed low in the WAIT cycle of a store of 0xFFFF to 0x40C -> outputs 0, state IDLE, ready=1; later load of 0x40C does not return 0xFFFF (preloaded 0).
REQ-037 The bench SHALL check: mem_r_en_in=mem_w_en_in=1 at 0x410 with val_rm_in=0xA5 -> word 4 = 0xA5; mem_r_en_out=0.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM state type and default memory geometry for the MEM stage
package mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;
  localparam int DEF_MEM_WORDS = 64;
  localparam int DEF_BASE_ADDR = 1024;
endpackage

// File: rtl/data_memory.sv
// data_memory: word-addressed data array, synchronous write, asynchronous read
module data_memory #(
  parameter int DEPTH = mem_pkg::DEF_MEM_WORDS,
  parameter int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [DEPTH];
  // contents are deliberately not reset
  always_ff @(posedge clk)
    if (we_i) mem_q[addr_i] <= wdata_i;
  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage with multi-cycle data-memory access and MEM/WB register
module mem_stage
  import mem_pkg::*;
#(
  parameter int MEM_WORDS   = DEF_MEM_WORDS,
  parameter int BASE_ADDR   = DEF_BASE_ADDR,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic [31:0] alu_res_in,
  input  logic [31:0] val_rm_in,
  input  logic [3:0]  dst_in,
  output logic        ready,
  output logic        wb_en_out,
  output logic        mem_r_en_out,
  output logic [31:0] alu_res_out,
  output logic [31:0] mem_data_out,
  output logic [3:0]  dst_out
);
  localparam int AW = MEM_WORDS > 1 ? $clog2(MEM_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);
  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        req, rd, we;
  logic [31:0] word;
  logic [AW-1:0] addr;
  logic [31:0] rdata;
  logic        wb_en_q, mem_r_en_q;
  logic [31:0] alu_res_q, mem_data_q;
  logic [3:0]  dst_q;
  assign req   = mem_r_en_in | mem_w_en_in;
  // a simultaneous read+write is treated as a pure write
  assign rd    = mem_r_en_in & ~mem_w_en_in;
  assign word  = (alu_res_in - 32'(BASE_ADDR)) >> 2;
  assign addr  = AW'(word % 32'(MEM_WORDS));
  assign ready = !rst || state_q == DONE || (state_q == IDLE && !req);
  // the store lands on the edge that closes the DONE cycle
  assign we    = state_q == DONE && mem_w_en_in;
  data_memory #(.DEPTH(MEM_WORDS), .AW(AW)) u_mem (
    .clk    (clk),
    .we_i   (we),
    .addr_i (addr),
    .wdata_i(val_rm_in),
    .rdata_o(rdata)
  );
  // access sequencer: IDLE -> WAIT for WAIT_CYCLES-1 cycles -> DONE -> IDLE
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else
      case (state_q)
        IDLE: begin
          state_q <= !req ? IDLE : (WAIT_CYCLES == 1 ? DONE : WAIT);
          cnt_q   <= req ? CNT_INIT : cnt_q;
        end
        WAIT: begin
          cnt_q   <= cnt_q - 4'd1;
          state_q <= cnt_q <= 4'd1 ? DONE : WAIT;
        end
        default: state_q <= IDLE;
      endcase
  // MEM/WB register: load when ready, otherwise insert a bubble and keep the data
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      alu_res_q  <= '0;
      mem_data_q <= '0;
      dst_q      <= '0;
    end else if (ready) begin
      wb_en_q    <= wb_en_in;
      mem_r_en_q <= rd;
      alu_res_q  <= alu_res_in;
      mem_data_q <= rd ? rdata : mem_data_q;
      dst_q      <= dst_in;
    end else begin
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
    end
  assign wb_en_out    = wb_en_q;
  assign mem_r_en_out = mem_r_en_q;
  assign alu_res_out  = alu_res_q;
  assign mem_data_out = mem_data_q;
  assign dst_out      = dst_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed table, reset-abort sequence and randomized model check of mem_stage
module tb_mem_stage;
  import mem_pkg::*;
  localparam int WC = 2;
  logic clk = 1'b0, rst = 1'b0;
  logic wb_en_in = 0, mem_r_en_in = 0, mem_w_en_in = 0;
  logic [31:0] alu_res_in = 0, val_rm_in = 0;
  logic [3:0] dst_in = 0;
  logic ready, wb_en_out, mem_r_en_out;
  logic [31:0] alu_res_out, mem_data_out;
  logic [3:0] dst_out;
  int n_chk = 0, n_fail = 0;
  logic [31:0] mdl [64];
  logic [31:0] prev_md;

  mem_stage #(.MEM_WORDS(64), .BASE_ADDR(1024), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst(rst), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .alu_res_in(alu_res_in), .val_rm_in(val_rm_in),
    .dst_in(dst_in), .ready(ready), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .alu_res_out(alu_res_out), .mem_data_out(mem_data_out), .dst_out(dst_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r, w, wb;
    logic [31:0] a, d;
    logic [3:0] ds;
    int stall;
    logic e_wb, e_r;
    logic [31:0] e_alu, e_md;
    logic [3:0] e_dst;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // spec-level memory model: word index wraps modulo the depth
  task automatic model_step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    int idx;
    idx = int'((a - 32'd1024) / 32'd4) % 64;
    if (r && !w) prev_md = mdl[idx];
    if (w) mdl[idx] = d;
  endtask

  task automatic run_op(input logic r, input logic w, input logic wb, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] ds, output int stalls);
    @(negedge clk);
    mem_r_en_in = r; mem_w_en_in = w; wb_en_in = wb;
    alu_res_in = a; val_rm_in = d; dst_in = ds;
    stalls = 0;
    #1;
    while (!ready && stalls < 40) begin
      @(posedge clk); #1;
      chk("stall_bubble_wb", 32'(wb_en_out), 32'd0);
      stalls++;
      @(negedge clk); #1;
    end
    if (!ready) chk("ready_timeout", 32'(ready), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_out(input string tag, input logic e_wb, input logic e_r,
                           input logic [31:0] e_alu, input logic [31:0] e_md, input logic [3:0] e_dst);
    chk({tag, "_wb"}, 32'(wb_en_out), 32'(e_wb));
    chk({tag, "_rd"}, 32'(mem_r_en_out), 32'(e_r));
    chk({tag, "_alu"}, alu_res_out, e_alu);
    chk({tag, "_md"}, mem_data_out, e_md);
    chk({tag, "_dst"}, 32'(dst_out), 32'(e_dst));
  endtask

  initial begin
    int st;
    logic r, w, wb;
    logic [31:0] a, d;
    logic [3:0] ds;
    tbl[0] = '{1'b0, 1'b0, 1'b1, 32'h5,   32'h0,        4'd3, 0,  1'b1, 1'b0, 32'h5,   32'h0,        4'd3};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 32'h408, 32'hDEADBEEF, 4'd0, WC, 1'b0, 1'b0, 32'h408, 32'h0,        4'd0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 32'h408, 32'h0,        4'd7, WC, 1'b1, 1'b1, 32'h408, 32'hDEADBEEF, 4'd7};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 32'h500, 32'h1234,     4'd0, WC, 1'b0, 1'b0, 32'h500, 32'hDEADBEEF, 4'd0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 32'h400, 32'h0,        4'd1, WC, 1'b1, 1'b1, 32'h400, 32'h1234,     4'd1};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 32'h410, 32'hA5,       4'd2, WC, 1'b1, 1'b0, 32'h410, 32'h1234,     4'd2};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 32'h410, 32'h0,        4'd5, WC, 1'b1, 1'b1, 32'h410, 32'hA5,       4'd5};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 32'h40A, 32'h0,        4'd6, WC, 1'b1, 1'b1, 32'h40A, 32'hDEADBEEF, 4'd6};
    for (int i = 0; i < 64; i++) mdl[i] = 32'h0;
    prev_md = 32'h0;
    // reset state, including ready=1 while a request is present
    mem_r_en_in = 1'b1;
    #2;
    chk("reset_ready", 32'(ready), 32'd1);
    check_out("reset", 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    mem_r_en_in = 1'b0;
    @(negedge clk); rst = 1'b1;
    // zero the whole array through the normal store path
    for (int i = 0; i < 64; i++) run_op(1'b0, 1'b1, 1'b0, 32'h400 + 32'(i * 4), 32'h0, 4'd0, st);
    // directed table
    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].r, tbl[i].w, tbl[i].wb, tbl[i].a, tbl[i].d, tbl[i].ds, st);
      chk($sformatf("tbl%0d_stall", i), 32'(st), 32'(tbl[i].stall));
      check_out($sformatf("tbl%0d", i), tbl[i].e_wb, tbl[i].e_r, tbl[i].e_alu, tbl[i].e_md, tbl[i].e_dst);
      model_step(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d);
    end
    // back-to-back: the cycle after DONE must stall again
    @(negedge clk);
    mem_r_en_in = 1'b1; mem_w_en_in = 1'b0; wb_en_in = 1'b1; alu_res_in = 32'h408; dst_in = 4'd4;
    #1 chk("b2b_idle_req_ready", 32'(ready), 32'd0);
    @(negedge clk); #1 chk("b2b_wait_ready", 32'(ready), 32'd0);
    @(negedge clk); #1 chk("b2b_done_ready", 32'(ready), 32'd1);
    @(negedge clk); #1 chk("b2b_restart_ready", 32'(ready), 32'd0);
    @(negedge clk); #1 chk("b2b_wait2_ready", 32'(ready), 32'd0);
    @(negedge clk); #1 chk("b2b_done2_ready", 32'(ready), 32'd1);
    @(posedge clk); #1;
    check_out("b2b", 1'b1, 1'b1, 32'h408, 32'hDEADBEEF, 4'd4);
    model_step(1'b1, 1'b0, 32'h408, 32'h0);
    // reset during the WAIT cycle of a store aborts it
    @(negedge clk);
    mem_r_en_in = 1'b0; mem_w_en_in = 1'b1; wb_en_in = 1'b0; alu_res_in = 32'h40C; val_rm_in = 32'hFFFF; dst_in = 4'd0;
    @(posedge clk); #2;
    chk("pre_abort_state", 32'(dut.state_q), 32'(WAIT));
    rst = 1'b0;
    #1;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_state", 32'(dut.state_q), 32'(IDLE));
    check_out("abort", 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
    @(posedge clk);
    @(negedge clk);
    mem_w_en_in = 1'b0; val_rm_in = 32'h0;
    rst = 1'b1;
    prev_md = 32'h0;
    run_op(1'b1, 1'b0, 1'b1, 32'h40C, 32'h0, 4'd9, st);
    chk("abort_load_stall", 32'(st), 32'(WC));
    chk("abort_load_not_ffff", 32'(mem_data_out == 32'hFFFF), 32'd0);
    check_out("abort_load", 1'b1, 1'b1, 32'h40C, 32'h0, 4'd9);
    model_step(1'b1, 1'b0, 32'h40C, 32'h0);
    // randomized operations against the model
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0: begin r = 1'b0; w = 1'b0; end
        1: begin r = 1'b1; w = 1'b0; end
        2: begin r = 1'b0; w = 1'b1; end
        default: begin r = 1'b1; w = 1'b1; end
      endcase
      wb = 1'($urandom);
      a = 32'h400 + 32'($urandom_range(0, 2047));
      d = $urandom;
      ds = 4'($urandom);
      run_op(r, w, wb, a, d, ds, st);
      model_step(r, w, a, d);
      chk($sformatf("rnd%0d_stall", i), 32'(st), (r | w) ? 32'(WC) : 32'd0);
      check_out($sformatf("rnd%0d", i), wb, r & ~w, a, prev_md, ds);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
